// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer ALU blocks: default width, sequencer states and a
// constant-foldable ceil(log2) helper.
package int_alu_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mult_state_e;

  // Usable in parameter expressions; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/int_adder.sv
// Plain unsigned adder; the multiplier sequencer shares one instance for all accumulate steps.
module int_adder #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  // Carry-out is dropped: the accumulator is sized so the product cannot exceed Width bits.
  assign sum_o = a_i + b_i;

endmodule

// File: rtl/int_mult_seq_ctrl.sv
// Iterative unsigned shift-add multiplier: one operand pair in, DATA_WIDTH accumulate steps
// through a shared adder, full-width product out over a valid/ready handshake.
module int_mult_seq_ctrl
  import int_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] m_plier,
  input  logic [DATA_WIDTH-1:0] m_cand,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned CNT_W = clog2(DATA_WIDTH) + 1;
  localparam int unsigned AccW  = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(DATA_WIDTH - 1);

  mult_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] plier_q, plier_d;
  logic [AccW-1:0]       cand_q, cand_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [AccW-1:0]       acc_sum;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] res_lo_q, res_lo_d;
  logic [DATA_WIDTH-1:0] res_hi_q, res_hi_d;
  logic                  ovf_q, ovf_d;

  int_adder #(
    .Width (AccW)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (cand_q),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d     = state_q;
    plier_d     = plier_q;
    cand_d      = cand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    ovf_d       = ovf_q;

    case (state_q)
      StIdle: begin
        // abort is deliberately not looked at here: a new pair is always taken.
        if (in_valid) begin
          plier_d = m_plier;
          cand_d  = {{DATA_WIDTH{1'b0}}, m_cand};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (plier_q[0]) begin
            acc_d = acc_sum;
          end
          cand_d  = cand_q << 1;
          plier_d = plier_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        // First DONE cycle publishes the accumulator; the result then holds until taken.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          res_lo_d    = acc_q[DATA_WIDTH-1:0];
          res_hi_d    = acc_q[AccW-1:DATA_WIDTH];
          ovf_d       = |acc_q[AccW-1:DATA_WIDTH];
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      plier_q     <= '0;
      cand_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      plier_q     <= plier_d;
      cand_q      <= cand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign ovf       = ovf_q;

endmodule
